// File: rtl/rca_multicycle_seq.sv
// rtl/rca_multicycle_seq.sv - WIDTH-bit add sequenced LSB-first over one shared external 8-bit adder slice.
module rca_multicycle_seq #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_sum,
  input  logic             add_cout
);

  localparam int NS = WIDTH / 8;
  localparam logic [IDXW-1:0] LAST = IDXW'(NS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NS; i++) begin
          if (idx_q == IDXW'(i)) sum_d[8*i +: 8] = add_sum;
        end
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Adder is driven only in RUN so it sees a quiet zero input otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_cin = carry_q;
      for (int i = 0; i < NS; i++) begin
        if (idx_q == IDXW'(i)) begin
          add_a = a_q[8*i +: 8];
          add_b = b_q[8*i +: 8];
        end
      end
    end
  end

  // Results are exposed only in DONE, never the partially filled sum.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    out_sum   = out_valid ? sum_q : '0;
    out_cout  = out_valid & carry_q;
    out_ovf   = out_valid & (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_q[WIDTH-1] != a_q[WIDTH-1]);
  end

endmodule

// File: tb/tb_rca_multicycle_seq.sv
// tb/tb_rca_multicycle_seq.sv - directed self-checking bench for rca_multicycle_seq (WIDTH 32 and 8).
module tb_rca_multicycle_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, busy;
  logic [31:0] in_a, in_b, out_sum;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  logic        v8_in_valid, v8_in_ready, v8_in_cin, v8_out_valid, v8_out_ready, v8_out_cout, v8_out_ovf, v8_busy;
  logic [7:0]  v8_in_a, v8_in_b, v8_out_sum;
  logic [7:0]  v8_add_a, v8_add_b, v8_add_sum;
  logic        v8_add_cin, v8_add_cout;

  int checks = 0;
  int errors = 0;

  assign {add_cout, add_sum}       = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign {v8_add_cout, v8_add_sum} = {1'b0, v8_add_a} + {1'b0, v8_add_b} + {8'd0, v8_add_cin};

  rca_multicycle_seq #(.WIDTH(32), .IDXW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  rca_multicycle_seq #(.WIDTH(8), .IDXW(3)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_a(v8_in_a), .in_b(v8_in_b), .in_cin(v8_in_cin),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_sum(v8_out_sum), .out_cout(v8_out_cout),
    .out_ovf(v8_out_ovf), .busy(v8_busy),
    .add_a(v8_add_a), .add_b(v8_add_b), .add_cin(v8_add_cin), .add_sum(v8_add_sum), .add_cout(v8_add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic c);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] s, input logic c, input logic o);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_cout"}, out_cout, c);
    chk({tag, "_ovf"}, out_ovf, o);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("back_to_idle", in_ready, 1);
  endtask

  logic [31:0] held_sum;

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    v8_in_valid = 0; v8_in_a = 0; v8_in_b = 0; v8_in_cin = 0; v8_out_ready = 0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_add_a", {add_a, add_b, 7'd0, add_cin}, 0);

    // 1: slices presented LSB first, result at accept+4
    start_op(32'h12345678, 32'h11111111, 1'b1);
    chk("t1_in_ready_run", in_ready, 0);
    chk("t1_add_a0", add_a, 8'h78);
    chk("t1_add_cin0", add_cin, 1);
    tick(); chk("t1_add_a1", add_a, 8'h56);
    tick(); chk("t1_add_a2", add_a, 8'h34);
    tick(); chk("t1_add_a3", add_a, 8'h12);
    chk("t1_not_valid_yet", out_valid, 0);
    tick();
    check_result("t1", 32'h2345678A, 0, 0);
    chk("t1_idle_adder", {add_a, add_b, 7'd0, add_cin}, 0);
    release_result();

    // 2: carry ripples across every slice
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    chk("t2_cin0", add_cin, 0);
    tick(); chk("t2_cin1", add_cin, 1);
    tick(); chk("t2_cin2", add_cin, 1);
    tick(); chk("t2_cin3", add_cin, 1);
    tick();
    check_result("t2", 32'h00000000, 1, 0);
    release_result();

    // 3: signed overflow
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    repeat (4) tick();
    check_result("t3", 32'h80000000, 0, 1);
    release_result();

    // 4: backpressure with in_valid toggling during DONE
    start_op(32'h00000005, 32'h00000006, 1'b0);
    repeat (4) tick();
    check_result("t4a", 32'h0000000B, 0, 0);
    held_sum = out_sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a = 32'h100 + i; in_b = 32'h200;
      tick();
      chk("t4_hold_sum", out_sum, held_sum);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b1; in_a = 32'h100; in_b = 32'h200; in_cin = 0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_idle_no_accept", {in_ready, busy}, 2'b10);
    tick();
    in_valid = 1'b0;
    chk("t4_accepted", {in_ready, busy}, 2'b01);
    repeat (3) tick();
    chk("t4_not_valid_yet", out_valid, 0);
    tick();
    check_result("t4b", 32'h00000300, 0, 0);
    release_result();

    // 5: asynchronous reset mid-RUN
    start_op(32'hAAAAAAAA, 32'h55555555, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_sum", out_sum, 0);
    chk("t5_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_op(32'd1, 32'd2, 1'b0);
    repeat (4) tick();
    check_result("t5", 32'd3, 0, 0);
    release_result();

    // 6: single-slice instance
    v8_in_a = 8'h80; v8_in_b = 8'h80; v8_in_cin = 0; v8_in_valid = 1'b1;
    tick();
    v8_in_valid = 1'b0;
    chk("t6_run", {v8_busy, v8_out_valid}, 2'b10);
    chk("t6_add_a", v8_add_a, 8'h80);
    tick();
    chk("t6_valid", v8_out_valid, 1);
    chk("t6_sum", v8_out_sum, 8'h00);
    chk("t6_cout", v8_out_cout, 1);
    chk("t6_ovf", v8_out_ovf, 1);
    v8_out_ready = 1'b1;
    tick();
    v8_out_ready = 1'b0;
    chk("t6_idle", v8_in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
